// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle control FSM for the 16-bit datapath
module mc_controller #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [OPW-1:0] opext,
    input  logic           cond_true,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           ir_en,
    output logic           reg_we,
    output logic           flag_en,
    output logic           mem_re,
    output logic           mem_we,
    output logic           addr_sel,
    output logic           alu_src_imm,
    output logic [1:0]     pc_src,
    output logic [1:0]     wb_sel,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_reg_we;
    logic       r_flag_en;
    logic       r_mem_re;
    logic       r_mem_we;
    logic       r_addr_sel;
    logic       r_alu_src_imm;
    logic [1:0] r_pc_src;
    logic [1:0] r_wb_sel;

    logic w_cmp;
    logic w_load;
    logic w_pc_en;
    logic w_ir_en;

    // Compare writes flags only; LOAD vs STOR is the only choice made in MEM_ADDR
    assign w_cmp  = ((op == OPW'(0)) && (opext == OPW'(11))) || (op == OPW'(11));
    assign w_load = (opext == OPW'(0));

    // Next-state selection; a low reset forces FETCH so state and outputs clear together
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OPW'(0)) begin
                    w_next = S_EXEC_R;
                end else if (op == OPW'(4)) begin
                    case (opext)
                        OPW'(0), OPW'(4): w_next = S_MEM_ADDR;
                        OPW'(8):          w_next = S_JAL;
                        OPW'(12):         w_next = S_JUMP;
                        default:          w_next = S_FETCH;
                    endcase
                end else if (op == OPW'(12)) begin
                    w_next = S_BRANCH;
                end else begin
                    w_next = S_EXEC_I;
                end
            end
            S_EXEC_R,
            S_EXEC_I:   w_next = w_cmp ? S_FETCH : S_ALU_WB;
            S_MEM_ADDR: w_next = w_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            default:    w_next = S_FETCH;
        endcase
        if (!reset) begin
            w_next = S_FETCH;
        end
    end

    // State register plus Moore outputs precomputed from the state being entered
    always_ff @(posedge clk) begin
        r_state       <= w_next;
        r_reg_we      <= (w_next == S_ALU_WB) || (w_next == S_MEM_WB) || (w_next == S_JAL);
        r_flag_en     <= (w_next == S_EXEC_R) || (w_next == S_EXEC_I);
        r_mem_re      <= (w_next == S_FETCH) || (w_next == S_MEM_RD);
        r_mem_we      <= (w_next == S_MEM_WR);
        r_addr_sel    <= (w_next == S_MEM_ADDR) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR);
        // ALU_WB keeps the immediate operand selected when it came from EXEC_I
        r_alu_src_imm <= (w_next == S_EXEC_I) || ((w_next == S_ALU_WB) && (r_state == S_EXEC_I));
        r_pc_src      <= (w_next == S_BRANCH) ? 2'b01 :
                         ((w_next == S_JUMP) || (w_next == S_JAL)) ? 2'b10 : 2'b00;
        r_wb_sel      <= (w_next == S_MEM_WB) ? 2'b01 :
                         (w_next == S_JAL) ? 2'b10 : 2'b00;
    end

    // PC/IR loads depend on this cycle's memory handshake or branch condition
    assign w_ir_en = (r_state == S_FETCH) && mem_ready;
    assign w_pc_en = w_ir_en
                   || (((r_state == S_BRANCH) || (r_state == S_JUMP)) && cond_true)
                   || (r_state == S_JAL);

    // Reset masks every output in the same cycle so an aborted instruction writes nothing
    assign pc_en       = reset & w_pc_en;
    assign ir_en       = reset & w_ir_en;
    assign reg_we      = reset & r_reg_we;
    assign flag_en     = reset & r_flag_en;
    assign mem_re      = reset & r_mem_re;
    assign mem_we      = reset & r_mem_we;
    assign addr_sel    = reset & r_addr_sel;
    assign alu_src_imm = reset & r_alu_src_imm;
    assign pc_src      = {2{reset}} & r_pc_src;
    assign wb_sel      = {2{reset}} & r_wb_sel;
    assign state       = reset ? r_state : 4'd0;

endmodule
